// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed data RAM, zeroed by a clear FSM after reset.
// Optional MMIO window (cycle/store counters, io regs) built when DMEM_MMIO_EN is defined.
module dmem_responder #(
   parameter int unsigned ADDR_WIDTH = 12,
   parameter logic [31:0] MMIO_BASE  = 32'hFFFF_FF00
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] address_dmem,
   input  logic [31:0] data,
   input  logic        wren,
   output logic [31:0] q_dmem,
   output logic        ready,
   input  logic [31:0] io_in,
   output logic [31:0] io_out
);

   localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

   typedef enum logic {
      CLEAR,
      RUN
   } state_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] ptr;
   logic [31:0]           mem [DEPTH];

   logic [ADDR_WIDTH-1:0] idx;
   logic                  mmio_hit;
   logic [31:0]           mmio_rd;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_wa;
   logic [31:0]           mem_wd;

   assign idx = address_dmem[ADDR_WIDTH-1:0];

`ifdef DMEM_MMIO_EN
   logic [31:0] cyc_cnt;
   logic [31:0] st_cnt;
   logic [31:0] sync1;
   logic [31:0] sync2;

   assign mmio_hit = (address_dmem[31:2] == MMIO_BASE[31:2]);

   always_comb begin
      mmio_rd = '0;
      unique case (address_dmem[1:0])
         2'd0: mmio_rd = cyc_cnt;
         2'd1: mmio_rd = io_out;
         2'd2: mmio_rd = sync2;
         2'd3: mmio_rd = st_cnt;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cyc_cnt <= '0;
         st_cnt  <= '0;
         sync1   <= '0;
         sync2   <= '0;
         io_out  <= '0;
      end else begin
         sync1 <= io_in;
         sync2 <= sync1;
         if (state == RUN) begin
            cyc_cnt <= cyc_cnt + 32'd1;
            if (wren && !mmio_hit)
               st_cnt <= st_cnt + 32'd1;
            // only offset 1 is writable; other MMIO stores vanish
            if (wren && mmio_hit && address_dmem[1:0] == 2'd1)
               io_out <= data;
         end
      end
   end
`else
   logic unused_pins;

   assign mmio_hit    = 1'b0;
   assign mmio_rd     = '0;
   assign io_out      = '0;
   assign unused_pins = ^{io_in, address_dmem[31:ADDR_WIDTH]};
`endif

   // single write port shared by the clear sweep and processor stores
   assign mem_we = !reset && (state == CLEAR || (wren && !mmio_hit));
   assign mem_wa = (state == CLEAR) ? ptr : idx;
   assign mem_wd = (state == CLEAR) ? '0 : data;

   always_ff @(posedge clock) begin
      if (mem_we)
         mem[mem_wa] <= mem_wd;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state  <= CLEAR;
         ptr    <= '0;
         ready  <= 1'b0;
         q_dmem <= '0;
      end else begin
         unique case (state)
            CLEAR: begin
               q_dmem <= '0;
               ptr    <= ptr + 1'b1;
               if (&ptr) begin
                  state <= RUN;
                  ready <= 1'b1;
               end
            end
            RUN: begin
               if (mmio_hit)
                  q_dmem <= mmio_rd;
               else if (wren)
                  q_dmem <= data;
               else
                  q_dmem <= mem[idx];
            end
         endcase
      end
   end

endmodule
